uart_tx_scheduler: RTL and testbench

//  Shares one UART transmit line between N byte sources (motor telemetry, status, debug).

---
 rtl/uart_tx_scheduler_pkg.sv | 18 +
 rtl/uart_byte_ser.sv | 57 +++++
 rtl/uart_tx_scheduler.sv | 142 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared FSM encodings and defaults for the UART TX scheduler.
// CHK state exists only when UART_SCHED_CHECKSUM_EN is defined.
package uart_tx_scheduler_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_ID   = 3'd2;
    localparam logic [2:0] ST_DAT  = 3'd3;
`ifdef UART_SCHED_CHECKSUM_EN
    localparam logic [2:0] ST_CHK  = 3'd4;
`endif

    localparam logic [7:0] HDR_DEFAULT   = 8'hA5;
    localparam int         BITS_PER_BYTE = 10;
    // 100 MHz core clock, 250 kBd line
    localparam int         DIV_DEFAULT   = 400;

endpackage

// File: rtl/uart_byte_ser.sv
// 8N1 LSB-first serializer, DIV cycles per bit; TX drops one cycle after start is sampled.
// done marks the last stop-bit cycle; a start in that cycle chains the next byte with no gap.
module uart_byte_ser
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       done,
    output logic       tx
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          active;

    assign done = active && (bit_cnt == 4'(BITS_PER_BYTE - 1)) && (div_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx      <= 1'b1;
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start && (!active || done)) begin
            // stop bit rides in the MSB so it shifts out after D7
            shreg   <= {1'b1, byte_in};
            tx      <= 1'b0;
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (active) begin
            if (div_cnt == CW'(DIV - 1)) begin
                div_cnt <= '0;
                if (bit_cnt == 4'(BITS_PER_BYTE - 1)) begin
                    active  <= 1'b0;
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b0, shreg[8:1]};
                end
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter + frame FSM sharing one UART TX (HDR, ID, DATA[, CHK]); start bit 2 cycles after grant edge.
// REQ is ignored while BUSY; checksum byte enabled by UART_SCHED_CHECKSUM_EN.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int          N_REQ    = 4,
    parameter int          DIV      = DIV_DEFAULT,
    parameter logic [7:0]  HDR_BYTE = HDR_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] DATA,
    output logic [N_REQ-1:0]   ACK,
    output logic [2:0]         GRANT_ID,
    output logic               BUSY,
    output logic               TX
);

    logic [2:0]       state;
    logic [2:0]       ptr;
    logic [7:0]       data_q;
    logic             kick;
    logic             start_q;
    logic [7:0]       req_pad;
    logic [63:0]      data_pad;
    logic [3:0]       sum;
    logic [2:0]       gnt_idx;
    logic             gnt_vld;
    logic [2:0]       ptr_next;
    logic [N_REQ-1:0] ack_next;
    logic             ser_start;
    logic             ser_done;
    logic [7:0]       ser_byte;
    logic             last_byte;

    // search order starts at the pointer and wraps at N_REQ
    always_comb begin
        req_pad                = '0;
        req_pad[N_REQ-1:0]     = REQ;
        data_pad               = '0;
        data_pad[8*N_REQ-1:0]  = DATA;
        gnt_vld                = 1'b0;
        gnt_idx                = '0;
        sum                    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + 4'(i);
            if (sum >= 4'(N_REQ))
                sum = sum - 4'(N_REQ);
            if (!gnt_vld && req_pad[sum[2:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = sum[2:0];
            end
        end
        ptr_next = (gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
        ack_next = '0;
        for (int k = 0; k < N_REQ; k++)
            ack_next[k] = (gnt_idx == 3'(k));
    end

    always_comb begin
        ser_byte = HDR_BYTE;
        case (state)
            ST_HDR:  ser_byte = start_q ? HDR_BYTE : {5'b0, GRANT_ID};
            ST_ID:   ser_byte = data_q;
`ifdef UART_SCHED_CHECKSUM_EN
            ST_DAT:  ser_byte = {5'b0, GRANT_ID} ^ data_q;
`endif
            default: ser_byte = HDR_BYTE;
        endcase
    end

`ifdef UART_SCHED_CHECKSUM_EN
    assign last_byte = (state == ST_CHK);
`else
    assign last_byte = (state == ST_DAT);
`endif

    // first byte launches from start_q; the rest chain off done
    assign ser_start = start_q | (ser_done & ~last_byte);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            data_q   <= '0;
            kick     <= 1'b0;
            start_q  <= 1'b0;
            ACK      <= '0;
            GRANT_ID <= '0;
            BUSY     <= 1'b0;
        end else begin
            ACK     <= '0;
            kick    <= 1'b0;
            start_q <= kick;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        ACK      <= ack_next;
                        GRANT_ID <= gnt_idx;
                        data_q   <= data_pad[{gnt_idx, 3'b000} +: 8];
                        BUSY     <= 1'b1;
                        kick     <= 1'b1;
                        ptr      <= ptr_next;
                        state    <= ST_HDR;
                    end
                end
                ST_HDR: if (ser_done) state <= ST_ID;
                ST_ID:  if (ser_done) state <= ST_DAT;
                ST_DAT: begin
                    if (ser_done) begin
`ifdef UART_SCHED_CHECKSUM_EN
                        state <= ST_CHK;
`else
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
`endif
                    end
                end
`ifdef UART_SCHED_CHECKSUM_EN
                ST_CHK: begin
                    if (ser_done) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_byte_ser #(.DIV(DIV)) u_ser (
        .clk     (CLK),
        .rst     (RST),
        .start   (ser_start),
        .byte_in (ser_byte),
        .done    (ser_done),
        .tx      (TX)
    );

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with N_REQ=4, DIV=4.
module tb_uart_tx_scheduler;

    localparam int DIV = 4;
`ifdef UART_SCHED_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic        CLK  = 1'b0;
    logic        RST  = 1'b1;
    logic [3:0]  REQ  = '0;
    logic [31:0] DATA = '0;
    logic [3:0]  ACK;
    logic [2:0]  GRANT_ID;
    logic        BUSY;
    logic        TX;

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] cap [4];
    bit         cap_to;
    logic [3:0] ack_seen;
    bit         idle_seen;
    bit         idle_to;

    uart_tx_scheduler #(.N_REQ(4), .DIV(DIV), .HDR_BYTE(8'hA5)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA),
        .ACK(ACK), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .TX(TX)
    );

    always #5 CLK = ~CLK;

    function automatic logic [9:0] exp_word(input int b, input logic [2:0] id, input logic [7:0] d);
        logic [7:0] v;
        case (b)
            0:       v = 8'hA5;
            1:       v = {5'b0, id};
            2:       v = d;
            default: v = {5'b0, id} ^ d;
        endcase
        return {1'b1, v, 1'b0};
    endfunction

    // samples each bit 2.5 cycles into its DIV window, bytes assumed back-to-back
    task automatic capture_frame(input int nbytes);
        int n = 0;
        cap_to = 1'b0;
        do begin
            @(negedge CLK);
            n++;
        end while (TX !== 1'b0 && n < 20);
        if (TX !== 1'b0) begin
            cap_to = 1'b1;
            return;
        end
        for (int b = 0; b < nbytes; b++)
            for (int j = 0; j < 10; j++) begin
                repeat ((b == 0 && j == 0) ? 2 : DIV) @(negedge CLK);
                cap[b][j] = TX;
            end
    endtask

    task automatic wait_ack();
        ack_seen  = '0;
        idle_seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge CLK);
            if (BUSY === 1'b0) idle_seen = 1'b1;
            if (ACK !== 4'b0000) begin
                ack_seen = ACK;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        idle_to = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            if (BUSY === 1'b0) begin
                idle_to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL rst_tx: got %b want 1", TX); end
        n_vec++; if (ACK !== 4'b0000) begin n_err++; $display("FAIL rst_ack: got %b want 0000", ACK); end
        n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        n_vec++; if (GRANT_ID !== 3'd0) begin n_err++; $display("FAIL rst_gid: got %0d want 0", GRANT_ID); end
        RST = 1'b0;
        @(negedge CLK);
        n_vec++; if (TX !== 1'b1 || BUSY !== 1'b0) begin n_err++; $display("FAIL idle_after_rst: tx %b busy %b want 1 0", TX, BUSY); end
    endtask

    task automatic test_single();
        @(negedge CLK);
        REQ = 4'b0001; DATA = 32'h0000_003C;
        @(negedge CLK);
        n_vec++; if (ACK !== 4'b0001) begin n_err++; $display("FAIL t1_ack: got %b want 0001", ACK); end
        n_vec++; if (BUSY !== 1'b1 || GRANT_ID !== 3'd0) begin n_err++; $display("FAIL t1_grant: busy %b gid %0d want 1 0", BUSY, GRANT_ID); end
        REQ = 4'b0000;
        @(negedge CLK);
        n_vec++; if (ACK !== 4'b0000) begin n_err++; $display("FAIL t1_ack_pulse: got %b want 0000", ACK); end
        capture_frame(NB);
        n_vec++; if (cap_to !== 1'b0) begin n_err++; $display("FAIL t1_start_timeout: got %b want 0", cap_to); end
        for (int b = 0; b < NB; b++) begin
            n_vec++;
            if (cap[b] !== exp_word(b, 3'd0, 8'h3C)) begin
                n_err++; $display("FAIL t1_byte%0d: got %h want %h", b, cap[b], exp_word(b, 3'd0, 8'h3C));
            end
        end
        @(negedge CLK);
        n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL t1_busy_last_cycle: got %b want 1", BUSY); end
        @(negedge CLK);
        n_vec++; if (BUSY !== 1'b0 || TX !== 1'b1) begin n_err++; $display("FAIL t1_busy_end: busy %b tx %b want 0 1", BUSY, TX); end
    endtask

    task automatic test_round_robin();
        logic [2:0] ids [3];
        logic [7:0] d;
        ids[0] = 3'd1; ids[1] = 3'd3; ids[2] = 3'd1;
        @(negedge CLK);
        REQ = 4'b1010; DATA = 32'h3300_1100;
        for (int k = 0; k < 3; k++) begin
            d = (ids[k] == 3'd1) ? 8'h11 : 8'h33;
            wait_ack();
            n_vec++; if (ack_seen !== (4'b0001 << ids[k])) begin n_err++; $display("FAIL rr%0d_ack: got %b want %b", k, ack_seen, 4'b0001 << ids[k]); end
            n_vec++; if (GRANT_ID !== ids[k]) begin n_err++; $display("FAIL rr%0d_gid: got %0d want %0d", k, GRANT_ID, ids[k]); end
            if (k > 0) begin
                n_vec++; if (idle_seen !== 1'b1) begin n_err++; $display("FAIL rr%0d_idle_gap: got %b want 1", k, idle_seen); end
            end
            if (k == 2) REQ = 4'b0000;
            capture_frame(NB);
            n_vec++; if (cap_to !== 1'b0) begin n_err++; $display("FAIL rr%0d_timeout: got %b want 0", k, cap_to); end
            n_vec++; if (cap[1] !== exp_word(1, ids[k], d)) begin n_err++; $display("FAIL rr%0d_id: got %h want %h", k, cap[1], exp_word(1, ids[k], d)); end
            n_vec++; if (cap[2] !== exp_word(2, ids[k], d)) begin n_err++; $display("FAIL rr%0d_data: got %h want %h", k, cap[2], exp_word(2, ids[k], d)); end
        end
        wait_idle();
        n_vec++; if (idle_to !== 1'b0) begin n_err++; $display("FAIL rr_idle_timeout: got %b want 0", idle_to); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        @(negedge CLK);
        REQ = 4'b0010; DATA = 32'h0000_0000;
        wait_ack();
        n_vec++; if (ack_seen !== 4'b0010) begin n_err++; $display("FAIL rm_ack: got %b want 0010", ack_seen); end
        REQ = 4'b0000;
        while (TX !== 1'b0 && n < 20) begin @(negedge CLK); n++; end
        repeat (90) @(negedge CLK);
        n_vec++; if (BUSY !== 1'b1 || TX !== 1'b0) begin n_err++; $display("FAIL rm_mid_data: busy %b tx %b want 1 0", BUSY, TX); end
        RST = 1'b1;
        #1;
        n_vec++; if (TX !== 1'b1 || BUSY !== 1'b0) begin n_err++; $display("FAIL rm_async: tx %b busy %b want 1 0", TX, BUSY); end
        n_vec++; if (GRANT_ID !== 3'd0 || ACK !== 4'b0000) begin n_err++; $display("FAIL rm_regs: gid %0d ack %b want 0 0000", GRANT_ID, ACK); end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        REQ = 4'b0101; DATA = 32'h00C3_005A;
        @(negedge CLK);
        n_vec++; if (ACK !== 4'b0001 || GRANT_ID !== 3'd0) begin n_err++; $display("FAIL rm_ptr_reset: ack %b gid %0d want 0001 0", ACK, GRANT_ID); end
        REQ = 4'b0000;
        capture_frame(NB);
        for (int b = 0; b < 3; b++) begin
            n_vec++;
            if (cap[b] !== exp_word(b, 3'd0, 8'h5A)) begin
                n_err++; $display("FAIL rm_byte%0d: got %h want %h", b, cap[b], exp_word(b, 3'd0, 8'h5A));
            end
        end
        wait_idle();
    endtask

    task automatic test_checksum();
        @(negedge CLK);
        REQ = 4'b0100; DATA = 32'h00F0_0000;
        wait_ack();
        n_vec++; if (ack_seen !== 4'b0100 || GRANT_ID !== 3'd2) begin n_err++; $display("FAIL ck_grant: ack %b gid %0d want 0100 2", ack_seen, GRANT_ID); end
        REQ = 4'b0000;
        capture_frame(NB);
        for (int b = 0; b < NB; b++) begin
            n_vec++;
            if (cap[b] !== exp_word(b, 3'd2, 8'hF0)) begin
                n_err++; $display("FAIL ck_byte%0d: got %h want %h", b, cap[b], exp_word(b, 3'd2, 8'hF0));
            end
        end
        repeat (2) @(negedge CLK);
        n_vec++; if (BUSY !== 1'b0 || TX !== 1'b1) begin n_err++; $display("FAIL ck_end: busy %b tx %b want 0 1", BUSY, TX); end
    endtask

    task automatic test_req_while_busy();
        int acks = 0;
        bit busy_again = 1'b0;
        @(negedge CLK);
        REQ = 4'b1000; DATA = 32'h7700_0000;
        wait_ack();
        REQ = 4'b0000;
        repeat (30) @(negedge CLK);
        REQ = 4'b0001; DATA = 32'h0000_0081;
        @(negedge CLK);
        REQ = 4'b0000;
        for (int n = 0; n < 300 && BUSY !== 1'b0; n++) begin
            @(negedge CLK);
            if (ACK !== 4'b0000) acks++;
        end
        repeat (10) begin
            @(negedge CLK);
            if (ACK !== 4'b0000) acks++;
            if (BUSY !== 1'b0) busy_again = 1'b1;
        end
        n_vec++; if (acks != 0) begin n_err++; $display("FAIL wb_pulse_ack: got %0d acks want 0", acks); end
        n_vec++; if (busy_again !== 1'b0) begin n_err++; $display("FAIL wb_pulse_frame: got busy %b want 0", busy_again); end
        REQ = 4'b0001;
        wait_ack();
        n_vec++; if (ack_seen !== 4'b0001) begin n_err++; $display("FAIL wb_held_ack: got %b want 0001", ack_seen); end
        REQ = 4'b0000;
        capture_frame(NB);
        n_vec++; if (cap[2] !== exp_word(2, 3'd0, 8'h81)) begin n_err++; $display("FAIL wb_held_data: got %h want %h", cap[2], exp_word(2, 3'd0, 8'h81)); end
        wait_idle();
    endtask

    task automatic test_bit_timing();
        logic cur;
        int len = 1;
        int first_len = 0;
        int bad = 0;
        @(negedge CLK);
        REQ = 4'b0010; DATA = 32'h0000_0000;
        @(negedge CLK);
        n_vec++; if (ACK !== 4'b0010 || TX !== 1'b1) begin n_err++; $display("FAIL bt_e0: ack %b tx %b want 0010 1", ACK, TX); end
        REQ = 4'b0000;
        @(negedge CLK);
        n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL bt_e1_tx: got %b want 1", TX); end
        @(negedge CLK);
        n_vec++; if (TX !== 1'b0) begin n_err++; $display("FAIL bt_start_edge: got %b want 0", TX); end
        cur = 1'b0;
        for (int c = 1; c < NB * 40; c++) begin
            @(negedge CLK);
            if (TX === cur) len++;
            else begin
                if (first_len == 0) first_len = len;
                if (len % DIV != 0) bad++;
                cur = TX;
                len = 1;
            end
        end
        n_vec++; if (first_len != DIV) begin n_err++; $display("FAIL bt_start_len: got %0d want %0d", first_len, DIV); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bt_run_len: got %0d bad runs want 0", bad); end
        wait_idle();
        n_vec++; if (idle_to !== 1'b0) begin n_err++; $display("FAIL bt_idle_timeout: got %b want 0", idle_to); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reset_mid();
        test_checksum();
        test_req_while_busy();
        test_bit_timing();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
